ili9341_spi_rx: RTL

- Receive-side model of the ILI9341 4-wire serial interface: an SPI slave (mode 0, MSB first) with a D/CX line.
- Deserialises command and parameter bytes, tracks the CASET/PASET address window, and turns RAMWR data into addressed 16-bit pixel writes.
- Used as the display-side peer of our TFT controller, both in simulation benches and as an on-chip display emulator feeding a framebuffer.

---
 rtl/ili9341_spi_rx_if.sv | 43 ++++
 rtl/ili9341_spi_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_spi_rx_if.sv
// ----------------------------------------------------------------------------
// ili9341_spi_rx_if
// Bundles the ILI9341 4-wire serial bus (chip select, clock, data, D/CX) with
// the decoded byte and pixel-write outputs of the receiver.
//
//   tftChipSelect / tftSck / tftMosi / dataCtrl : serial bus, driven by the
//                                                 TFT controller (master)
//   cmdValid, cmdByte                           : received command byte
//   paramValid, paramByte, paramIndex           : received parameter byte
//   pixValid, pixX, pixY, pixColor, frameDone   : addressed pixel writes
//
// slave  : the display-side receiver
// master : the controller side (or a bench) driving the bus
// ----------------------------------------------------------------------------
interface ili9341_spi_rx_if;
    logic        tftChipSelect;
    logic        tftSck;
    logic        tftMosi;
    logic        dataCtrl;

    logic        cmdValid;
    logic [7:0]  cmdByte;
    logic        paramValid;
    logic [7:0]  paramByte;
    logic [3:0]  paramIndex;
    logic        pixValid;
    logic [15:0] pixX;
    logic [15:0] pixY;
    logic [15:0] pixColor;
    logic        frameDone;

    modport slave (
        input  tftChipSelect, tftSck, tftMosi, dataCtrl,
        output cmdValid, cmdByte, paramValid, paramByte, paramIndex,
        output pixValid, pixX, pixY, pixColor, frameDone
    );

    modport master (
        output tftChipSelect, tftSck, tftMosi, dataCtrl,
        input  cmdValid, cmdByte, paramValid, paramByte, paramIndex,
        input  pixValid, pixX, pixY, pixColor, frameDone
    );
endinterface

// File: rtl/ili9341_spi_rx.sv
// ----------------------------------------------------------------------------
// ili9341_spi_rx
// Display-side receiver for the ILI9341 4-wire serial interface (SPI mode 0,
// MSB first, D/CX line). Deserialises command and parameter bytes, tracks the
// CASET/PASET address window and turns RAMWR data into addressed RGB565 pixel
// writes.
//
// Ports:
//   CLK_I : system clock; all SPI inputs are oversampled on it
//   RST_I : synchronous active-high reset
//   bus   : ili9341_spi_rx_if.slave - serial inputs and decoded outputs
//
// Parameters:
//   COLS_ : panel width  (default column window end = COLS_-1)
//   ROWS_ : panel height (default row window end    = ROWS_-1)
// ----------------------------------------------------------------------------
module ili9341_spi_rx #(
    parameter int COLS_ = 240,
    parameter int ROWS_ = 320
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    ili9341_spi_rx_if.slave    bus
);

    localparam logic [15:0] COL_END_RST = 16'(COLS_ - 1);
    localparam logic [15:0] ROW_END_RST = 16'(ROWS_ - 1);

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CASET = 2'd1;
    localparam logic [1:0] ST_PASET = 2'd2;
    localparam logic [1:0] ST_RAMWR = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronisers: bit [1] of each pair is the usable synced copy.
    // ------------------------------------------------------------------
    logic [1:0] cs_ff;
    logic [1:0] sck_ff;
    logic [1:0] mosi_ff;
    logic [1:0] dcx_ff;
    logic       sck_prev;
    logic       sck_rise;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            // NOTE: synchroniser flops are reset too, to the idle bus levels
            // (cs high, sck low), so no phantom edge is seen on release.
            cs_ff    <= 2'b11;
            sck_ff   <= 2'b00;
            mosi_ff  <= 2'b00;
            dcx_ff   <= 2'b00;
            sck_prev <= 1'b0;
        end else begin
            cs_ff    <= {cs_ff[0],   bus.tftChipSelect};
            sck_ff   <= {sck_ff[0],  bus.tftSck};
            mosi_ff  <= {mosi_ff[0], bus.tftMosi};
            dcx_ff   <= {dcx_ff[0],  bus.dataCtrl};
            sck_prev <= sck_ff[1];
        end
    end

    assign sck_rise = sck_ff[1] & ~sck_prev;

    // ------------------------------------------------------------------
    // Bit assembly. A completed byte is presented for one cycle on
    // byte_done together with its D/CX value (captured with the last bit).
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic       rx_dcx;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            byte_done <= 1'b0;
            rx_byte   <= 8'd0;
            rx_dcx    <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_ff[1]) begin
                // Deselect drops any partial byte.
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi_ff[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {shift, mosi_ff[1]};
                    rx_dcx    <= dcx_ff[1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command / parameter decoder, address window and pixel cursor.
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [3:0]  param_cnt;
    logic        phase;
    logic [7:0]  pix_hi;
    logic [15:0] col_start;
    logic [15:0] col_end;
    logic [15:0] row_start;
    logic [15:0] row_end;
    logic [15:0] cur_x;
    logic [15:0] cur_y;

    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        param_valid;
    logic [7:0]  param_byte;
    logic [3:0]  param_index;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_color;
    logic        frame_done;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state       <= ST_IDLE;
            param_cnt   <= 4'd0;
            phase       <= 1'b0;
            pix_hi      <= 8'd0;
            col_start   <= 16'd0;
            col_end     <= COL_END_RST;
            row_start   <= 16'd0;
            row_end     <= ROW_END_RST;
            cur_x       <= 16'd0;
            cur_y       <= 16'd0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'd0;
            param_valid <= 1'b0;
            param_byte  <= 8'd0;
            param_index <= 4'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 16'd0;
            pix_y       <= 16'd0;
            pix_color   <= 16'd0;
            frame_done  <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            param_valid <= 1'b0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;

            if (byte_done && !rx_dcx) begin
                // Command byte: restart parameter numbering and drop any
                // half-received pixel.
                cmd_valid <= 1'b1;
                cmd_byte  <= rx_byte;
                param_cnt <= 4'd0;
                phase     <= 1'b0;
                case (rx_byte)
                    CMD_CASET: state <= ST_CASET;
                    CMD_PASET: state <= ST_PASET;
                    CMD_RAMWR: begin
                        state <= ST_RAMWR;
                        pix_x <= col_start;
                        pix_y <= row_start;
                        cur_x <= col_start;
                        cur_y <= row_start;
                    end
                    CMD_SWRESET: begin
                        state     <= ST_IDLE;
                        col_start <= 16'd0;
                        col_end   <= COL_END_RST;
                        row_start <= 16'd0;
                        row_end   <= ROW_END_RST;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (byte_done) begin
                // Parameter / data byte: always reported, index saturates.
                param_valid <= 1'b1;
                param_byte  <= rx_byte;
                param_index <= param_cnt;
                if (param_cnt != 4'hF) begin
                    param_cnt <= param_cnt + 4'd1;
                end

                case (state)
                    ST_CASET: begin
                        case (param_cnt)
                            4'd0:    col_start[15:8] <= rx_byte;
                            4'd1:    col_start[7:0]  <= rx_byte;
                            4'd2:    col_end[15:8]   <= rx_byte;
                            4'd3:    col_end[7:0]    <= rx_byte;
                            default: ;
                        endcase
                    end
                    ST_PASET: begin
                        case (param_cnt)
                            4'd0:    row_start[15:8] <= rx_byte;
                            4'd1:    row_start[7:0]  <= rx_byte;
                            4'd2:    row_end[15:8]   <= rx_byte;
                            4'd3:    row_end[7:0]    <= rx_byte;
                            default: ;
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!phase) begin
                            pix_hi <= rx_byte;
                            phase  <= 1'b1;
                        end else begin
                            phase      <= 1'b0;
                            pix_valid  <= 1'b1;
                            pix_x      <= cur_x;
                            pix_y      <= cur_y;
                            pix_color  <= {pix_hi, rx_byte};
                            frame_done <= (cur_x >= col_end) && (cur_y >= row_end);
                            // ">=" rather than "==" so a window programmed
                            // with start > end still wraps every pixel.
                            if (cur_x >= col_end) begin
                                cur_x <= col_start;
                                if (cur_y >= row_end) begin
                                    cur_y <= row_start;
                                end else begin
                                    cur_y <= cur_y + 16'd1;
                                end
                            end else begin
                                cur_x <= cur_x + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.cmdValid   = cmd_valid;
    assign bus.cmdByte    = cmd_byte;
    assign bus.paramValid = param_valid;
    assign bus.paramByte  = param_byte;
    assign bus.paramIndex = param_index;
    assign bus.pixValid   = pix_valid;
    assign bus.pixX       = pix_x;
    assign bus.pixY       = pix_y;
    assign bus.pixColor   = pix_color;
    assign bus.frameDone  = frame_done;

endmodule
